// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM pipeline stage. Registers EX results, aligns stores onto
//               byte lanes, runs a req/ready handshake to data memory while
//               stalling upstream, and returns right-justified load data to
//               write-back. Flags misaligned, illegal and timed-out accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EX_MEM_READ,
    input  logic        EX_MEM_WRITE,
    input  logic [2:0]  EX_FUNC3,
    input  logic [31:0] EX_ALU_RESULT,
    input  logic [31:0] EX_RS2_DATA,
    input  logic [31:0] EX_JAL_SELECTED,
    input  logic        EX_WRITE_ENABLE,
    input  logic        EX_DATA_MEM_SELECT,
    input  logic [4:0]  EX_RD,
    output logic        MEM_STALL,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [3:0]  DMEM_BYTE_EN,
    output logic [31:0] DMEM_WDATA,
    input  logic [31:0] DMEM_RDATA,
    input  logic        DMEM_READY,
    output logic [2:0]  MEM_FUNC3,
    output logic        MEM_WRITE_ENABLE,
    output logic        MEM_DATA_MEM_SELECT,
    output logic [31:0] MEM_JAL_SELECTED,
    output logic [31:0] MEM_DATA_OUT,
    output logic [4:0]  MEM_RD,
    output logic        MEM_FAULT,
    output logic [31:0] MEM_FAULT_ADDR
);

    // Counter only needs to reach TIMEOUT_CYCLES; a zero timeout disables it.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               dmem_req_q, dmem_req_d;
    logic               dmem_we_q, dmem_we_d;
    logic [31:0]        dmem_addr_q, dmem_addr_d;
    logic [3:0]         dmem_byte_en_q, dmem_byte_en_d;
    logic [31:0]        dmem_wdata_q, dmem_wdata_d;

    logic [2:0]         mem_func3_q, mem_func3_d;
    logic               mem_write_enable_q, mem_write_enable_d;
    logic               mem_data_mem_select_q, mem_data_mem_select_d;
    logic [31:0]        mem_jal_selected_q, mem_jal_selected_d;
    logic [31:0]        mem_data_out_q, mem_data_out_d;
    logic [4:0]         mem_rd_q, mem_rd_d;
    logic               mem_fault_q, mem_fault_d;
    logic [31:0]        mem_fault_addr_q, mem_fault_addr_d;

    // Operation saved while the access is outstanding (EX is not held stable for us).
    logic               op_load_q, op_load_d;
    logic [2:0]         op_func3_q, op_func3_d;
    logic               op_we_q, op_we_d;
    logic               op_dms_q, op_dms_d;
    logic [31:0]        op_jal_q, op_jal_d;
    logic [4:0]         op_rd_q, op_rd_d;
    logic [31:0]        op_addr_q, op_addr_d;

    logic               is_store, is_load, is_mem;
    logic               func3_ok, align_ok, legal;
    logic [3:0]         st_byte_en;
    logic [31:0]        st_wdata;
    logic               timed_out;

    // Decode the EX operation: kind, legality and store lane placement.
    always_comb begin
        is_store   = EX_MEM_WRITE;
        is_load    = EX_MEM_READ & ~EX_MEM_WRITE;
        is_mem     = is_store | is_load;
        func3_ok   = 1'b0;
        align_ok   = 1'b0;
        st_byte_en = 4'b1111;
        st_wdata   = EX_RS2_DATA;

        if (is_store) begin
            func3_ok = (EX_FUNC3 <= 3'b010);
        end else begin
            func3_ok = !(EX_FUNC3 inside {3'b011, 3'b110, 3'b111});
        end

        // Access size comes from the low two bits (LBU/LHU share LB/LH sizes).
        case (EX_FUNC3[1:0])
            2'b00: begin
                align_ok   = 1'b1;
                st_byte_en = 4'b0001 << EX_ALU_RESULT[1:0];
                st_wdata   = {4{EX_RS2_DATA[7:0]}};
            end
            2'b01: begin
                align_ok   = ~EX_ALU_RESULT[0];
                st_byte_en = EX_ALU_RESULT[1] ? 4'b1100 : 4'b0011;
                st_wdata   = {2{EX_RS2_DATA[15:0]}};
            end
            2'b10: begin
                align_ok   = (EX_ALU_RESULT[1:0] == 2'b00);
            end
            default: begin
                align_ok   = 1'b0;
            end
        endcase

        legal = func3_ok & align_ok;
    end

    // Timeout fires when the counter has reached the limit and memory still is not ready.
    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Next-state and next-output logic for the IDLE/ACCESS handshake.
    always_comb begin
        state_d               = state_q;
        cnt_d                 = cnt_q;
        dmem_req_d            = dmem_req_q;
        dmem_we_d             = dmem_we_q;
        dmem_addr_d           = dmem_addr_q;
        dmem_byte_en_d        = dmem_byte_en_q;
        dmem_wdata_d          = dmem_wdata_q;
        mem_func3_d           = mem_func3_q;
        mem_write_enable_d    = mem_write_enable_q;
        mem_data_mem_select_d = mem_data_mem_select_q;
        mem_jal_selected_d    = mem_jal_selected_q;
        mem_data_out_d        = mem_data_out_q;
        mem_rd_d              = mem_rd_q;
        mem_fault_d           = 1'b0;
        mem_fault_addr_d      = mem_fault_addr_q;
        op_load_d             = op_load_q;
        op_func3_d            = op_func3_q;
        op_we_d               = op_we_q;
        op_dms_d              = op_dms_q;
        op_jal_d              = op_jal_q;
        op_rd_d               = op_rd_q;
        op_addr_d             = op_addr_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (is_mem) begin
                    // Memory ops leave a bubble until they complete.
                    mem_func3_d           = 3'b000;
                    mem_write_enable_d    = 1'b0;
                    mem_data_mem_select_d = 1'b0;
                    mem_jal_selected_d    = 32'h0;
                    mem_data_out_d        = 32'h0;
                    mem_rd_d              = 5'd0;
                    if (legal) begin
                        op_load_d      = is_load;
                        op_func3_d     = EX_FUNC3;
                        op_we_d        = EX_WRITE_ENABLE;
                        op_dms_d       = EX_DATA_MEM_SELECT;
                        op_jal_d       = EX_JAL_SELECTED;
                        op_rd_d        = EX_RD;
                        op_addr_d      = EX_ALU_RESULT;
                        dmem_req_d     = 1'b1;
                        dmem_we_d      = is_store;
                        dmem_addr_d    = {EX_ALU_RESULT[31:2], 2'b00};
                        dmem_byte_en_d = is_store ? st_byte_en : 4'b0000;
                        dmem_wdata_d   = is_store ? st_wdata : 32'h0;
                        state_d        = S_ACCESS;
                    end else begin
                        mem_fault_d      = 1'b1;
                        mem_fault_addr_d = EX_ALU_RESULT;
                    end
                end else begin
                    mem_func3_d           = EX_FUNC3;
                    mem_write_enable_d    = EX_WRITE_ENABLE;
                    mem_data_mem_select_d = EX_DATA_MEM_SELECT;
                    mem_jal_selected_d    = EX_JAL_SELECTED;
                    mem_data_out_d        = 32'h0;
                    mem_rd_d              = EX_RD;
                end
            end

            S_ACCESS: begin
                if (DMEM_READY || timed_out) begin
                    dmem_req_d     = 1'b0;
                    dmem_we_d      = 1'b0;
                    dmem_byte_en_d = 4'b0000;
                    cnt_d          = '0;
                    state_d        = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end

                // READY takes priority over a timeout on the same edge.
                if (DMEM_READY) begin
                    mem_func3_d           = op_func3_q;
                    mem_write_enable_d    = op_we_q;
                    mem_data_mem_select_d = op_dms_q;
                    mem_jal_selected_d    = op_jal_q;
                    mem_rd_d              = op_rd_q;
                    mem_data_out_d        = op_load_q ? (DMEM_RDATA >> {op_addr_q[1:0], 3'b000}) : 32'h0;
                end else if (timed_out) begin
                    mem_write_enable_d    = 1'b0;
                    mem_fault_d           = 1'b1;
                    mem_fault_addr_d      = op_addr_q;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q               <= S_IDLE;
            cnt_q                 <= '0;
            dmem_req_q            <= 1'b0;
            dmem_we_q             <= 1'b0;
            dmem_addr_q           <= 32'h0;
            dmem_byte_en_q        <= 4'b0000;
            dmem_wdata_q          <= 32'h0;
            mem_func3_q           <= 3'b000;
            mem_write_enable_q    <= 1'b0;
            mem_data_mem_select_q <= 1'b0;
            mem_jal_selected_q    <= 32'h0;
            mem_data_out_q        <= 32'h0;
            mem_rd_q              <= 5'd0;
            mem_fault_q           <= 1'b0;
            mem_fault_addr_q      <= 32'h0;
            op_load_q             <= 1'b0;
            op_func3_q            <= 3'b000;
            op_we_q               <= 1'b0;
            op_dms_q              <= 1'b0;
            op_jal_q              <= 32'h0;
            op_rd_q               <= 5'd0;
            op_addr_q             <= 32'h0;
        end else begin
            state_q               <= state_d;
            cnt_q                 <= cnt_d;
            dmem_req_q            <= dmem_req_d;
            dmem_we_q             <= dmem_we_d;
            dmem_addr_q           <= dmem_addr_d;
            dmem_byte_en_q        <= dmem_byte_en_d;
            dmem_wdata_q          <= dmem_wdata_d;
            mem_func3_q           <= mem_func3_d;
            mem_write_enable_q    <= mem_write_enable_d;
            mem_data_mem_select_q <= mem_data_mem_select_d;
            mem_jal_selected_q    <= mem_jal_selected_d;
            mem_data_out_q        <= mem_data_out_d;
            mem_rd_q              <= mem_rd_d;
            mem_fault_q           <= mem_fault_d;
            mem_fault_addr_q      <= mem_fault_addr_d;
            op_load_q             <= op_load_d;
            op_func3_q            <= op_func3_d;
            op_we_q               <= op_we_d;
            op_dms_q              <= op_dms_d;
            op_jal_q              <= op_jal_d;
            op_rd_q               <= op_rd_d;
            op_addr_q             <= op_addr_d;
        end
    end

    assign MEM_STALL           = (state_q == S_ACCESS);
    assign DMEM_REQ            = dmem_req_q;
    assign DMEM_WE             = dmem_we_q;
    assign DMEM_ADDR           = dmem_addr_q;
    assign DMEM_BYTE_EN        = dmem_byte_en_q;
    assign DMEM_WDATA          = dmem_wdata_q;
    assign MEM_FUNC3           = mem_func3_q;
    assign MEM_WRITE_ENABLE    = mem_write_enable_q;
    assign MEM_DATA_MEM_SELECT = mem_data_mem_select_q;
    assign MEM_JAL_SELECTED    = mem_jal_selected_q;
    assign MEM_DATA_OUT        = mem_data_out_q;
    assign MEM_RD              = mem_rd_q;
    assign MEM_FAULT           = mem_fault_q;
    assign MEM_FAULT_ADDR      = mem_fault_addr_q;

endmodule
`default_nettype wire
